fresh_input_parser: RTL and testbench
=====================================

// Module: fresh_input_parser
// PURPOSE
//   Upstream stage of the fresh-ingredient identifier. Parses the raw ASCII puzzle input byte stream
//   into range records and check IDs. Input format: "lo-hi\n" lines, one blank line, then "id\n" lines.
//   Range records feed the range-FIFO write side; IDs feed the check_addr side.
//   Runs on the range clock domain; the FIFO does the CDC.
// PARAMETERS
//   ADDR_W   17  width of range bounds and IDs; values must fit in ADDR_W bits
//   CNT_W    16  width of the record/ID counters
// PORTS
//   clk          in   1       clock
//   rst_n        in   1       synchronous reset, active-low
//   in_valid     in   1       byte on in_data is valid
//   in_ready     out  1       parser accepts a byte this cycle
//   in_data      in   8       ASCII byte
//   in_last      in   1       qualifies the final byte of the stream
//   rng_valid    out  1       range record valid; held until rng_ready
//   rng_ready    in   1       downstream accepts record (FIFO !full && !wr_rst_busy)
//   rng_low      out  ADDR_W  range low bound
//   rng_high     out  ADDR_W  range high bound (inclusive)
//   rng_fresh    out  1       constant 1 for parsed ranges
//   id_valid     out  1       check ID valid; held until id_ready
//   id_ready     in   1       downstream accepts ID
//   id_addr      out  ADDR_W  ID value
//   done         out  1       sticky; stream fully parsed and last output accepted
//   range_count  out  CNT_W   ranges handed off (wraps at 2^CNT_W)
//   id_count     out  CNT_W   IDs handed off (wraps at 2^CNT_W)
//   parse_err    out  1       sticky error flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all outputs 0 except in_ready=1. State=S_LO, accumulator=0, digit_seen=0.
//     Reset mid-record discards the partial number and any pending output.
//   - Byte accepted iff in_valid && in_ready. in_ready = !rng_valid && !id_valid && !done.
//   - Digit '0'..'9': acc <= acc*10 + digit. Internal width is ADDR_W+4. Sets digit_seen.
//   - '\r' is ignored in all states.
//   - States and transitions:
//     S_LO:     '-' with digit_seen -> latch lo, clear acc -> S_HI.
//               '\n' with !digit_seen (blank line) -> S_ID.
//     S_HI:     '\n' with digit_seen -> rng_low=lo, rng_high=acc, rng_valid=1 next cycle -> S_LO.
//     S_ID:     '\n' with digit_seen -> id_addr=acc, id_valid=1 next cycle.
//               '\n' with !digit_seen -> ignored.
//     S_DONE:   reached when in_last is accepted. A pending number is flushed first:
//               in S_HI it becomes a range; in S_ID it becomes an ID.
//               done=1 once no output is valid.
//   - Output latency: terminator byte accepted at cycle N -> valid asserted at cycle N+1.
//     Worst case is one stall cycle per record.
//   - A valid output holds its data stable until ready. Counters increment on valid&&ready.
//   - rng_valid and id_valid are never high together.
//   - in_last on a blank line in S_LO -> S_DONE with no output.
//   - Any byte after done is not accepted (in_ready=0).
// CONFIGURATION
//   PARSER_ERR_CHECK_EN defined:
//     - parse_err is set sticky on any of:
//       an illegal byte; '-' in S_HI or S_ID; a value exceeding 2^ADDR_W-1; lo>hi.
//     - An offending range/ID line is dropped up to its '\n'; parsing resumes after it.
//   PARSER_ERR_CHECK_EN undefined:
//     - parse_err is tied 0.
//     - Illegal bytes are ignored.
//     - Values are truncated to ADDR_W LSBs.
//     - lo>hi records pass unchanged.
// TESTING
//   1. "3-5\n10-14\n\n1\n5\n" with in_last on the final '\n', ready=1:
//      ranges (3,5), (10,14) then IDs 1, 5; done=1; range_count=2, id_count=2.
//   2. Backpressure: rng_ready=0 for 10 cycles after the first record:
//      rng_valid held with (3,5) stable, in_ready=0; resumes with no loss or duplication.
//   3. "\r\n" line endings and an extra blank line in the ID section:
//      same outputs as test 1; blank line ignored.
//   4. Stream ends "...\n\n131071" with in_last on '1' (no trailing '\n'):
//      ID 131071 flushed, then done=1.
//   5. rst_n=0 asserted for one cycle mid-number "12" of "12-20":
//      no record emitted; "7-9\n" afterwards yields (7,9).
//   6. With PARSER_ERR_CHECK_EN: "5-3\n", "200000-1\n", "4x-6\n":
//      parse_err=1, all three dropped, a following "1-2\n" yields (1,2).

Source files
------------

// File: rtl/fresh_input_parser.sv
// fresh_input_parser: parses "lo-hi" range lines, a blank line, then "id" lines from an ASCII byte stream.
// Optional malformed-line detection and dropping is enabled by defining PARSER_ERR_CHECK_EN.
module fresh_input_parser #(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              rng_valid,
    input  logic              rng_ready,
    output logic [ADDR_W-1:0] rng_low,
    output logic [ADDR_W-1:0] rng_high,
    output logic              rng_fresh,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_addr,
    output logic              done,
    output logic [CNT_W-1:0]  range_count,
    output logic [CNT_W-1:0]  id_count,
    output logic              parse_err
);
`ifdef PARSER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int AW = ADDR_W + 4;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] DASH = 8'h2D;

    typedef enum logic [1:0] {S_LO, S_HI, S_ID, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d, acc_next, num;
    logic              digit_seen_q, digit_seen_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic              rng_valid_q, rng_valid_d;
    logic [ADDR_W-1:0] rng_low_q, rng_low_d, rng_high_q, rng_high_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_addr_q, id_addr_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  range_count_q, range_count_d, id_count_q, id_count_d;
    logic              parse_err_q, parse_err_d;
    logic              accept, is_digit, bad, emit_rng, emit_id;

    assign in_ready    = !rng_valid_q && !id_valid_q && !done_q;
    assign rng_valid   = rng_valid_q;
    assign rng_low     = rng_low_q;
    assign rng_high    = rng_high_q;
    assign rng_fresh   = rng_valid_q;
    assign id_valid    = id_valid_q;
    assign id_addr     = id_addr_q;
    assign done        = done_q;
    assign range_count = range_count_q;
    assign id_count    = id_count_q;
    assign parse_err   = parse_err_q;

    always_comb begin
        accept        = in_valid && in_ready;
        is_digit      = in_data >= 8'h30 && in_data <= 8'h39;
        acc_next      = acc_q * AW'(10) + AW'(in_data[3:0]);
        state_d       = state_q;
        acc_d         = acc_q;
        digit_seen_d  = digit_seen_q;
        drop_d        = drop_q;
        lo_d          = lo_q;
        parse_err_d   = parse_err_q;
        rng_valid_d   = rng_valid_q && !rng_ready;
        rng_low_d     = rng_low_q;
        rng_high_d    = rng_high_q;
        id_valid_d    = id_valid_q && !id_ready;
        id_addr_d     = id_addr_q;
        range_count_d = range_count_q + CNT_W'(rng_valid_q && rng_ready);
        id_count_d    = id_count_q + CNT_W'(id_valid_q && id_ready);
        bad           = 1'b0;
        emit_rng      = 1'b0;
        emit_id       = 1'b0;
        if (accept) begin
            if (drop_q) begin
                drop_d = in_data != LF;
            end else if (is_digit) begin
                acc_d        = acc_next;
                digit_seen_d = 1'b1;
                bad          = ERR_EN && |acc_next[AW-1:ADDR_W];
            end else if (in_data == DASH) begin
                if (state_q == S_LO && digit_seen_q) begin
                    lo_d         = acc_q[ADDR_W-1:0];
                    acc_d        = '0;
                    digit_seen_d = 1'b0;
                    state_d      = S_HI;
                end else begin
                    bad = ERR_EN;
                end
            end else if (in_data == LF) begin
                acc_d        = '0;
                digit_seen_d = 1'b0;
                if (state_q == S_LO) begin
                    state_d = digit_seen_q ? S_LO : S_ID;
                    bad     = ERR_EN && digit_seen_q;
                end else if (state_q == S_HI) begin
                    state_d  = S_LO;
                    emit_rng = digit_seen_q;
                    bad      = ERR_EN && !digit_seen_q;
                end else begin
                    emit_id = digit_seen_q;
                end
            end else if (in_data != CR) begin
                bad = ERR_EN;
            end
            // A malformed line is discarded up to and including its newline
            if (bad) begin
                parse_err_d  = 1'b1;
                drop_d       = in_data != LF;
                acc_d        = '0;
                digit_seen_d = 1'b0;
                state_d      = (state_q == S_ID) ? S_ID : S_LO;
            end
            if (in_last) begin
                if (!drop_d && in_data != LF && digit_seen_d) begin
                    emit_rng = state_d == S_HI;
                    emit_id  = state_d == S_ID;
                end
                state_d = S_DONE;
            end
        end
        num = (in_data == LF) ? acc_q : acc_d;
        if (emit_rng && ERR_EN && lo_q > num[ADDR_W-1:0]) begin
            emit_rng    = 1'b0;
            parse_err_d = 1'b1;
        end
        if (emit_rng) begin
            rng_valid_d = 1'b1;
            rng_low_d   = lo_q;
            rng_high_d  = num[ADDR_W-1:0];
        end
        if (emit_id) begin
            id_valid_d = 1'b1;
            id_addr_d  = num[ADDR_W-1:0];
        end
        done_d = done_q || (state_d == S_DONE && !rng_valid_d && !id_valid_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_LO;
            acc_q         <= '0;
            digit_seen_q  <= 1'b0;
            drop_q        <= 1'b0;
            lo_q          <= '0;
            rng_valid_q   <= 1'b0;
            rng_low_q     <= '0;
            rng_high_q    <= '0;
            id_valid_q    <= 1'b0;
            id_addr_q     <= '0;
            done_q        <= 1'b0;
            range_count_q <= '0;
            id_count_q    <= '0;
            parse_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            digit_seen_q  <= digit_seen_d;
            drop_q        <= drop_d;
            lo_q          <= lo_d;
            rng_valid_q   <= rng_valid_d;
            rng_low_q     <= rng_low_d;
            rng_high_q    <= rng_high_d;
            id_valid_q    <= id_valid_d;
            id_addr_q     <= id_addr_d;
            done_q        <= done_d;
            range_count_q <= range_count_d;
            id_count_q    <= id_count_d;
            parse_err_q   <= parse_err_d;
        end
    end
endmodule

// File: tb/tb_fresh_input_parser.sv
// tb_fresh_input_parser: directed tests for fresh_input_parser with immediate-assertion checks.
module tb_fresh_input_parser;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_last;
    logic [7:0]  in_data;
    logic        rng_valid, rng_ready, rng_fresh, id_valid, id_ready, done, parse_err;
    logic [16:0] rng_low, rng_high, id_addr;
    logic [15:0] range_count, id_count;
    int          compared = 0;
    int          mismatched = 0;
    logic [33:0] rq[$];
    logic [16:0] iq[$];
    bit          both_seen = 1'b0;
    bit          fresh_bad = 1'b0;

    fresh_input_parser dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_low(rng_low),
        .rng_high(rng_high), .rng_fresh(rng_fresh), .id_valid(id_valid), .id_ready(id_ready),
        .id_addr(id_addr), .done(done), .range_count(range_count), .id_count(id_count),
        .parse_err(parse_err)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a handshake seen here completes at the next posedge
    always @(negedge clk) begin
        if (rst_n && rng_valid && rng_ready) begin
            rq.push_back({rng_low, rng_high});
            if (rng_fresh !== 1'b1) fresh_bad = 1'b1;
        end
        if (rst_n && id_valid && id_ready) iq.push_back(id_addr);
        if (rng_valid && id_valid) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int t = 0;
        in_data = b;
        in_last = last;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) send(s[i], last && i == s.len() - 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        rng_ready = 1'b1;
        id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rq.delete();
        iq.delete();
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("done", done, 1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_nrng"}, rq.size(), 2);
        chk({tag, "_r0"}, rq[0], {17'd3, 17'd5});
        chk({tag, "_r1"}, rq[1], {17'd10, 17'd14});
        chk({tag, "_nid"}, iq.size(), 2);
        chk({tag, "_i0"}, iq[0], 1);
        chk({tag, "_i1"}, iq[1], 5);
        chk({tag, "_rcnt"}, range_count, 2);
        chk({tag, "_icnt"}, id_count, 2);
        chk({tag, "_rdy_after_done"}, in_ready, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'h00;
        rng_ready = 1'b1;
        id_ready = 1'b1;
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rng_valid", rng_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rcnt", range_count, 0);
        chk("rst_icnt", id_count, 0);
        chk("rst_err", parse_err, 0);
        chk("rst_fresh", rng_fresh, 0);

        send_str("3-5\n10-14\n\n1\n5\n", 1'b1);
        wait_done();
        check_basic("t1");

        do_reset();
        rng_ready = 1'b0;
        send_str("3-5\n", 1'b0);
        chk("t2_latency_valid", rng_valid, 1);
        chk("t2_fresh", rng_fresh, 1);
        repeat (10) @(posedge clk);
        #2;
        chk("t2_hold_valid", rng_valid, 1);
        chk("t2_hold_data", {rng_low, rng_high}, {17'd3, 17'd5});
        chk("t2_hold_in_ready", in_ready, 0);
        chk("t2_hold_rcnt", range_count, 0);
        rng_ready = 1'b1;
        send_str("10-14\n\n1\n5\n", 1'b1);
        wait_done();
        check_basic("t2");

        do_reset();
        send_str("3-5\015\n10-14\015\n\015\n1\015\n\015\n5\015\n", 1'b1);
        wait_done();
        check_basic("t3");

        do_reset();
        send_str("1-2\n\n131071", 1'b1);
        wait_done();
        chk("t4_nrng", rq.size(), 1);
        chk("t4_r0", rq[0], {17'd1, 17'd2});
        chk("t4_nid", iq.size(), 1);
        chk("t4_i0", iq[0], 131071);
        chk("t4_icnt", id_count, 1);

        do_reset();
        send_str("4-9", 1'b1);
        wait_done();
        chk("t4b_nrng", rq.size(), 1);
        chk("t4b_r0", rq[0], {17'd4, 17'd9});

        do_reset();
        send_str("7-8\n", 1'b0);
        send(8'h0A, 1'b1);
        wait_done();
        chk("t4c_rcnt", range_count, 1);
        chk("t4c_icnt", id_count, 0);
        chk("t4c_nid", iq.size(), 0);

        do_reset();
        send_str("12", 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("t5_rst_rcnt", range_count, 0);
        send_str("7-9\n", 1'b0);
        settle();
        chk("t5_nrng", rq.size(), 1);
        chk("t5_r0", rq[0], {17'd7, 17'd9});
        chk("t5_done", done, 0);

        do_reset();
        send_str("5-3\n200000-1\n4x-6\n1-2\n", 1'b0);
        settle();
`ifdef PARSER_ERR_CHECK_EN
        chk("t6_err", parse_err, 1);
        chk("t6_nrng", rq.size(), 1);
        chk("t6_r0", rq[0], {17'd1, 17'd2});
        chk("t6_rcnt", range_count, 1);
`else
        chk("t6_err", parse_err, 0);
        chk("t6_nrng", rq.size(), 4);
        chk("t6_r0", rq[0], {17'd5, 17'd3});
        chk("t6_r1", rq[1], {17'd68928, 17'd1});
        chk("t6_r2", rq[2], {17'd4, 17'd6});
        chk("t6_r3", rq[3], {17'd1, 17'd2});
`endif

        chk("both_valid", both_seen, 0);
        chk("fresh_on_hs", fresh_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
